ifft_bfly_scheduler: RTL

IFFT_BFLY_SCHEDULER -- requirements
Module: ifft_bfly_scheduler

---
 rtl/ifft_bfly_scheduler_if.sv | 35 +++
 rtl/ifft_bfly_scheduler.sv | 138 +++++++++++++
 2 files changed

// File: rtl/ifft_bfly_scheduler_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ifft_bfly_scheduler_if : start/read/write/status bundle of scheduler |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface ifft_bfly_scheduler_if #(
  parameter int LOG2N = 6
);
  logic             start;
  logic             rdEn;
  logic [LOG2N-1:0] rdAddr1;
  logic [LOG2N-1:0] rdAddr2;
  logic [LOG2N-2:0] twAddr;
  logic             wrEn;
  logic [LOG2N-1:0] wrAddr1;
  logic [LOG2N-1:0] wrAddr2;
  logic [3:0]       stage;
  logic             busy;
  logic             done;

  modport master (
    input  start,
    output rdEn, rdAddr1, rdAddr2, twAddr,
    output wrEn, wrAddr1, wrAddr2,
    output stage, busy, done
  );

  modport slave (
    output start,
    input  rdEn, rdAddr1, rdAddr2, twAddr,
    input  wrEn, wrAddr1, wrAddr2,
    input  stage, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/ifft_bfly_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ifft_bfly_scheduler : in-place radix-2 DIT IFFT butterfly sequencer  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module ifft_bfly_scheduler #(
  parameter int LOG2N    = 6,
  parameter int RD_LAT   = 1,
  parameter int BFLY_LAT = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  ifft_bfly_scheduler_if.master    bus
);

  localparam int               c_L    = RD_LAT + BFLY_LAT;
  localparam int               c_CW   = (c_L > 1) ? $clog2(c_L) : 1;
  localparam logic [LOG2N-2:0] c_KMAX = '1;
  localparam logic [LOG2N-1:0] c_ONE  = 1;
  localparam logic [3:0]       c_LAST = 4'(LOG2N - 1);
  localparam logic [c_CW-1:0]  c_DEND = c_CW'(c_L - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [LOG2N-2:0] r_k, w_k_nxt;
  logic [3:0]       r_stage, w_stage_nxt;
  logic [c_CW-1:0]  r_cnt, w_cnt_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_k     <= '0;
      r_stage <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_k     <= w_k_nxt;
      r_stage <= w_stage_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_k_nxt     = r_k;
    w_stage_nxt = r_stage;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_state_nxt = RUN;
          w_k_nxt     = '0;
          w_stage_nxt = '0;
        end
      end
      RUN: begin
        if (r_k == c_KMAX) begin
          w_state_nxt = DRAIN;
          w_cnt_nxt   = '0;
        end else begin
          w_k_nxt = r_k + 1'b1;
        end
      end
      DRAIN: begin
        // Drain lasts exactly the read+butterfly latency so the final write lands before the next read
        if (r_cnt == c_DEND) begin
          if (r_stage == c_LAST) begin
            w_state_nxt = DONE;
          end else begin
            w_state_nxt = RUN;
            w_stage_nxt = r_stage + 4'd1;
            w_k_nxt     = '0;
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  logic             w_rd_en;
  logic [LOG2N-1:0] w_k_ext, w_span, w_pos, w_a1, w_a2, w_tw_full;

  // rdAddr1 = grp*2*span + pos: the group index shifted one bit past the pos field
  always_comb begin
    w_rd_en   = (r_state == RUN);
    w_k_ext   = {1'b0, r_k};
    w_span    = c_ONE << r_stage;
    w_pos     = w_k_ext & (w_span - c_ONE);
    w_a1      = ((w_k_ext >> r_stage) << (r_stage + 4'd1)) | w_pos;
    w_a2      = w_a1 + w_span;
    w_tw_full = w_pos << (c_LAST - r_stage);
  end

  logic             r_pipe_en [c_L];
  logic [LOG2N-1:0] r_pipe_a1 [c_L];
  logic [LOG2N-1:0] r_pipe_a2 [c_L];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < c_L; i++) begin
        r_pipe_en[i] <= 1'b0;
        r_pipe_a1[i] <= '0;
        r_pipe_a2[i] <= '0;
      end
    end else begin
      r_pipe_en[0] <= w_rd_en;
      r_pipe_a1[0] <= bus.rdAddr1;
      r_pipe_a2[0] <= bus.rdAddr2;
      for (int i = 1; i < c_L; i++) begin
        r_pipe_en[i] <= r_pipe_en[i-1];
        r_pipe_a1[i] <= r_pipe_a1[i-1];
        r_pipe_a2[i] <= r_pipe_a2[i-1];
      end
    end
  end

  // Addresses are forced to zero outside RUN so idle outputs stay quiet
  assign bus.rdEn    = w_rd_en;
  assign bus.rdAddr1 = w_rd_en ? w_a1 : '0;
  assign bus.rdAddr2 = w_rd_en ? w_a2 : '0;
  assign bus.twAddr  = w_rd_en ? w_tw_full[LOG2N-2:0] : '0;
  assign bus.wrEn    = r_pipe_en[c_L-1];
  assign bus.wrAddr1 = r_pipe_a1[c_L-1];
  assign bus.wrAddr2 = r_pipe_a2[c_L-1];
  assign bus.stage   = r_stage;
  assign bus.busy    = (r_state == RUN) || (r_state == DRAIN);
  assign bus.done    = (r_state == DONE);

endmodule
`default_nettype wire
